if_fetch_unit: RTL

//  Instruction-fetch front end and consumer of the PC register. Owns the PC,

---
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches words over req/ack and hands them to IF/ID.
// Optional macro FETCH_CNT_EN adds cnt_issued/cnt_killed event counters.
module if_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 'h3000,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [DATA_WIDTH-1:0] inst_pc
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]           cnt_issued,
  output logic [31:0]           cnt_killed
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0]   tgt_q;
  logic                    kill;

  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
    return a & ~DATA_WIDTH'(3);
  endfunction

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= NOP_INST;
      inst_pc    <= '0;
      kill       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            // A redirect arriving with the ack outranks any target parked in tgt_q.
            if (redirect) begin
              pc   <= word_align(redirect_pc);
              kill <= 1'b0;
            end else if (kill) begin
              pc   <= tgt_q;
              kill <= 1'b0;
            end else begin
              inst_out   <= imem_rdata;
              inst_pc    <= pc;
              pc         <= pc + DATA_WIDTH'(4);
              imem_req   <= 1'b0;
              inst_valid <= 1'b1;
              state      <= S_OUT;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect) begin
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            pc         <= word_align(redirect_pc);
            imem_req   <= 1'b1;
            state      <= S_REQ;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= S_REQ;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Pending redirect target while the old request is still in flight.
  always_ff @(posedge clk) begin
    if (state == S_REQ && !imem_ack && redirect)
      tgt_q <= word_align(redirect_pc);
  end

`ifdef FETCH_CNT_EN
  logic issue_evt;
  logic kill_evt;

  assign issue_evt = (state == S_OUT) && inst_ready && !redirect;
  assign kill_evt  = ((state == S_REQ) && imem_ack && (redirect || kill)) ||
                     ((state == S_OUT) && redirect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_issued <= '0;
      cnt_killed <= '0;
    end else begin
      if (issue_evt) cnt_issued <= cnt_issued + 32'd1;
      if (kill_evt)  cnt_killed <= cnt_killed + 32'd1;
    end
  end
`endif

endmodule
